instr_encoder: RTL and testbench
================================

# instr_encoder

- Program-loader engine: the inverse of the control decoder. It accepts symbolic instruction commands over a valid/ready handshake and packs them into 32-bit RV32I words.
- Writes the words sequentially into instruction memory through a request/acknowledge write port.
- Covers the same five opcode classes the core decodes: LOAD, OP-IMM, OP, STORE, BRANCH.
- Used by self-test and boot-time program generation ahead of the fetch stage.

## Interface
- ADDR_W, 6, word-address width of instruction memory; capacity 2^ADDR_W words
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; clears write counter and full; honored in IDLE/FULL only
- cmd_valid  in  1  command present
- cmd_ready  out  1  engine accepts command this cycle
- cmd_class  in  3  0=LOAD 1=OPIMM 2=OP 3=STORE 4=BRANCH; 5–7 illegal
- cmd_rd, cmd_rs1, cmd_rs2  in  5 each  register indices
- cmd_funct3  in  3  funct3 field
- cmd_f7b5  in  1  instruction bit 30 (SUB/SRA/SRAI)
- cmd_imm  in  13  signed immediate; bit 12 is the sign
- imem_we  out  1  write request, held until acknowledged
- imem_ack  in  1  memory accepted write this cycle
- imem_addr  out  ADDR_W  word address
- imem_wdata  out  32  encoded word
- count  out  ADDR_W+1  words written since reset/start
- full  out  1  count == 2^ADDR_W
- err  out  1  one-cycle pulse when an accepted command is rejected

## Operation
- FSM states: IDLE, WRITE, FULL.
- IDLE
  - cmd_ready=1.
  - On cmd_valid, latch the encoded word.
  - Legal command → WRITE.
  - Illegal class → pulse err, stay IDLE, no write.
- WRITE
  - cmd_ready=0; imem_we=1; imem_addr=count[ADDR_W-1:0]; imem_wdata stable.
  - On imem_ack: count++.
  - Next state is FULL if the new count == 2^ADDR_W, else IDLE.
- FULL
  - cmd_ready=0; full=1.
  - start → count=0, IDLE.
- start in IDLE: count=0; a cmd handshake in the same cycle is also accepted and writes address 0.
- start in WRITE: ignored; the write completes.
- Encoding; opcode set by class: 0000011, 0010011, 0110011, 0100011, 1100011.
  - LOAD/OPIMM: {imm[11:0], rs1, f3, rd, opc}.
  - OPIMM with f3=001/101: bits[31:25]={0, f7b5, 00000}, bits[24:20]=imm[4:0].
  - OP: {0, f7b5, 00000, rs2, rs1, f3, rd, opc}.
  - STORE: {imm[11:5], rs2, rs1, f3, imm[4:0], opc}.
  - BRANCH: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc}.
- Reset: state IDLE; count=0; imem_we=0; imem_addr=0; imem_wdata=0; err=0; full=0; cmd_ready=1 after reset release.
- Reset mid-WRITE aborts the write immediately; the word is lost.

## Timing
- Command accepted at edge N → imem_we=1 from N+1 (registered outputs).
- imem_ack sampled at edges; earliest completion at edge N+1 (ack in first WRITE cycle).
- cmd_ready returns in the cycle after completion.
- Peak throughput: one word per 2 cycles. Unbounded ack latency is allowed.
- err asserts in cycle N+1 for one cycle.
- count/full update on the ack edge.

## Configuration
- ENC_IMM_CHECK_EN defined: accepted commands are range-checked.
  - LOAD/OPIMM/STORE require imm[12]==imm[11].
  - OPIMM shifts require imm[11:5]==0.
  - BRANCH requires imm[0]==0.
  - Any violation pulses err; no write; stay IDLE.
- ENC_IMM_CHECK_EN undefined: no check; fields are truncated silently as per the encoding rules.

## Structure
- Shared package riscv_pkg:
  - Opcode localparams (OPC_LOAD, OPC_OPIMM, OPC_OP, OPC_STORE, OPC_BRANCH), shared with the control decoder.
  - cmd_class_t enum.
  - State enum.
- Sub-module rv_word_pack: purely combinational class/field → 32-bit packer plus illegal/range flags; instantiated once.
- The top level holds the FSM, counter and output registers.

## Test plan
- addi x1,x0,5 (class 1, rd=1, imm=5), ack immediate → word 0x00500093 at addr 0, count=1.
- lw x2,8(x1) then sw x2,4(x1), ack delayed 3 cycles → 0x0080A103 at addr 0, 0x0020A223 at addr 1; imem_we held 3 cycles each; cmd_ready=0 throughout.
- sub x3,x1,x2 (class 2, f7b5=1); beq x1,x2,-4 (class 4, imm=0x1FFC) → 0x402081B3, 0xFE208EE3.
- cmd_class=6 → err pulse one cycle, no imem_we, count unchanged.
  - With ENC_IMM_CHECK_EN: branch imm=3 → err.
- Fill 64 words (ADDR_W=6) → full=1 and cmd_ready=0 after the 64th ack; start → count=0, next write at addr 0.
- rst_n low during WRITE → imem_we=0 and count=0 asynchronously; after release, IDLE with cmd_ready=1.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions used by the control decoder and the program-loader engine.
// Opcodes, command classes and the loader FSM state encoding live here.
package riscv_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        CLS_LOAD   = 3'd0,
        CLS_OPIMM  = 3'd1,
        CLS_OP     = 3'd2,
        CLS_STORE  = 3'd3,
        CLS_BRANCH = 3'd4
    } cmd_class_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_FULL  = 2'd2
    } enc_state_t;

    // SLLI (001) and SRLI/SRAI (101) carry a shift amount instead of a 12-bit immediate
    function automatic logic is_shift_f3(input logic [2:0] f3);
        return (f3[1:0] == 2'b01);
    endfunction

endpackage

// File: rtl/rv_word_pack.sv
// Combinational packer: symbolic command fields -> 32-bit RV32I word plus illegal/range flags.
// Immediate range checking is compiled in only when ENC_IMM_CHECK_EN is defined.
module rv_word_pack
    import riscv_pkg::*;
(
    input  logic [2:0]  cls,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic        f7b5,
    input  logic [12:0] imm,
    output logic [31:0] word,
    output logic        illegal,
    output logic        range_err
);

    always_comb begin
        word    = 32'h0;
        illegal = 1'b0;
        case (cls)
            CLS_LOAD: begin
                word = {imm[11:0], rs1, funct3, rd, OPC_LOAD};
            end
            CLS_OPIMM: begin
                if (is_shift_f3(funct3)) begin
                    word = {1'b0, f7b5, 5'b00000, imm[4:0], rs1, funct3, rd, OPC_OPIMM};
                end else begin
                    word = {imm[11:0], rs1, funct3, rd, OPC_OPIMM};
                end
            end
            CLS_OP: begin
                word = {1'b0, f7b5, 5'b00000, rs2, rs1, funct3, rd, OPC_OP};
            end
            CLS_STORE: begin
                word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE};
            end
            CLS_BRANCH: begin
                word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OPC_BRANCH};
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

`ifdef ENC_IMM_CHECK_EN
    // 12-bit immediates must sign-extend cleanly from the 13-bit field
    always_comb begin
        range_err = 1'b0;
        case (cls)
            CLS_LOAD, CLS_STORE: begin
                range_err = (imm[12] != imm[11]);
            end
            CLS_OPIMM: begin
                range_err = (imm[12] != imm[11]) ||
                            (is_shift_f3(funct3) && (imm[11:5] != 7'b0000000));
            end
            CLS_BRANCH: begin
                range_err = imm[0];
            end
            default: begin
                range_err = 1'b0;
            end
        endcase
    end
`else
    assign range_err = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder.sv
// Program-loader engine: accepts symbolic commands, packs RV32I words and writes them sequentially.
// Optional ENC_IMM_CHECK_EN rejects commands whose immediates do not fit their encoding.
module instr_encoder
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_class,
    input  logic [4:0]        cmd_rd,
    input  logic [4:0]        cmd_rs1,
    input  logic [4:0]        cmd_rs2,
    input  logic [2:0]        cmd_funct3,
    input  logic              cmd_f7b5,
    input  logic [12:0]       cmd_imm,
    output logic              imem_we,
    input  logic              imem_ack,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err
);

    localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE      = {{ADDR_W{1'b0}}, 1'b1};

    enc_state_t       state;
    logic [31:0]      packed_word;
    logic             illegal;
    logic             range_err;
    logic             reject;
    logic [ADDR_W:0]  count_inc;

    rv_word_pack u_pack (
        .cls       (cmd_class),
        .rd        (cmd_rd),
        .rs1       (cmd_rs1),
        .rs2       (cmd_rs2),
        .funct3    (cmd_funct3),
        .f7b5      (cmd_f7b5),
        .imm       (cmd_imm),
        .word      (packed_word),
        .illegal   (illegal),
        .range_err (range_err)
    );

    assign reject    = illegal | range_err;
    assign count_inc = count + ONE;

    // cmd_ready mirrors ST_IDLE but is registered so every engine output comes from a flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            count      <= '0;
            full       <= 1'b0;
            err        <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'h0;
            cmd_ready  <= 1'b1;
        end else begin
            err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        count <= '0;
                    end
                    if (cmd_valid) begin
                        if (reject) begin
                            err <= 1'b1;
                        end else begin
                            state      <= ST_WRITE;
                            cmd_ready  <= 1'b0;
                            imem_we    <= 1'b1;
                            imem_wdata <= packed_word;
                            imem_addr  <= start ? '0 : count[ADDR_W-1:0];
                        end
                    end
                end
                ST_WRITE: begin
                    if (imem_ack) begin
                        imem_we <= 1'b0;
                        count   <= count_inc;
                        if (count_inc == CAPACITY) begin
                            state <= ST_FULL;
                            full  <= 1'b1;
                        end else begin
                            state     <= ST_IDLE;
                            cmd_ready <= 1'b1;
                        end
                    end
                end
                ST_FULL: begin
                    if (start) begin
                        state     <= ST_IDLE;
                        count     <= '0;
                        full      <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    cmd_ready <= 1'b1;
                    imem_we   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: scoreboard of expected writes vs. writes seen at the memory port.
// Honors ENC_IMM_CHECK_EN for the branch-immediate scenario.
module tb_instr_encoder;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_class;
    logic [4:0]        cmd_rd;
    logic [4:0]        cmd_rs1;
    logic [4:0]        cmd_rs2;
    logic [2:0]        cmd_funct3;
    logic              cmd_f7b5;
    logic [12:0]       cmd_imm;
    logic              imem_we;
    logic              imem_ack;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              err;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } exp_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        int                we_cycles;
        bit                ready_seen;
    } obs_t;

    exp_t exp_q[$];
    obs_t obs_q[$];
    int   ack_delay   = 0;
    int   model_count = 0;
    int   n_checks    = 0;
    int   n_pass      = 0;

    instr_encoder #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_class  (cmd_class),
        .cmd_rd     (cmd_rd),
        .cmd_rs1    (cmd_rs1),
        .cmd_rs2    (cmd_rs2),
        .cmd_funct3 (cmd_funct3),
        .cmd_f7b5   (cmd_f7b5),
        .cmd_imm    (cmd_imm),
        .imem_we    (imem_we),
        .imem_ack   (imem_ack),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .count      (count),
        .full       (full),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: acks after ack_delay waiting cycles and records each completed write
    initial begin
        int wait_cnt;
        int we_cyc;
        bit rdy_seen;
        imem_ack = 1'b0;
        wait_cnt = 0;
        we_cyc   = 0;
        rdy_seen = 0;
        forever begin
            @(posedge clk);
            #1;
            if (imem_ack) begin
                imem_ack = 1'b0;
            end else if (imem_we) begin
                we_cyc++;
                if (cmd_ready) rdy_seen = 1;
                if (wait_cnt >= ack_delay) begin
                    imem_ack = 1'b1;
                    obs_q.push_back('{imem_addr, imem_wdata, we_cyc, rdy_seen});
                    wait_cnt = 0;
                    we_cyc   = 0;
                    rdy_seen = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
                we_cyc   = 0;
                rdy_seen = 0;
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic send_cmd(input logic [2:0] cls, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [2:0] f3, input logic f7b5,
                            input logic [12:0] imm, input bit legal, input logic [31:0] exp_word,
                            input bit with_start);
        int guard;
        bit accepted;
        cmd_valid  = 1'b1;
        cmd_class  = cls;
        cmd_rd     = rd;
        cmd_rs1    = rs1;
        cmd_rs2    = rs2;
        cmd_funct3 = f3;
        cmd_f7b5   = f7b5;
        cmd_imm    = imm;
        start      = with_start;
        accepted   = 0;
        guard      = 0;
        while (!accepted && guard < 500) begin
            if (cmd_ready) accepted = 1;
            @(posedge clk);
            #1;
            start = 1'b0;
            guard++;
        end
        cmd_valid = 1'b0;
        if (!accepted) begin
            n_checks++;
            $display("[TB] FAIL cmd_handshake: cmd_ready=%0b after %0d cycles, required 1", cmd_ready, guard);
        end else if (legal) begin
            if (with_start) model_count = 0;
            exp_q.push_back('{model_count[ADDR_W-1:0], exp_word});
            model_count++;
        end
    endtask

    task automatic wait_obs(input int n);
        int g;
        g = 0;
        while (obs_q.size() < n && g < 1000) begin
            @(posedge clk);
            #1;
            g++;
        end
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; cmd_valid = 1'b0; cmd_class = '0; cmd_rd = '0;
        cmd_rs1 = '0; cmd_rs2 = '0; cmd_funct3 = '0; cmd_f7b5 = 1'b0; cmd_imm = '0;
        #3;
        n_checks++;
        if ({imem_we, err, full} !== 3'b000) $display("[TB] FAIL reset_flags: we/err/full=%b required 000", {imem_we, err, full});
        else n_pass++;
        n_checks++;
        if (count !== '0 || imem_addr !== '0 || imem_wdata !== 32'h0)
            $display("[TB] FAIL reset_regs: count=%0d addr=%0d wdata=%h required 0/0/0", count, imem_addr, imem_wdata);
        else n_pass++;
        #19 rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (cmd_ready !== 1'b1) $display("[TB] FAIL reset_ready: cmd_ready=%b required 1", cmd_ready);
        else n_pass++;
    endtask

    task automatic test_opimm();
        obs_t o;
        exp_t e;
        ack_delay = 0;
        send_cmd(3'd1, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 13'd5, 1, 32'h00500093, 0);
        wait_obs(1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) $display("[TB] FAIL addi_write: no write seen, required %h at %0d", e.data, e.addr);
            else begin
                o = obs_q.pop_front();
                if (o.addr !== e.addr || o.data !== e.data || o.we_cycles != 1)
                    $display("[TB] FAIL addi_write: got %h@%0d (%0d we cycles) required %h@%0d (1)", o.data, o.addr, o.we_cycles, e.data, e.addr);
                else n_pass++;
            end
        end
        n_checks++;
        if (count !== 7'd1) $display("[TB] FAIL addi_count: count=%0d required 1", count);
        else n_pass++;
    endtask

    task automatic test_load_store_delayed();
        obs_t o;
        exp_t e;
        ack_delay = 2;
        send_cmd(3'd0, 5'd2, 5'd1, 5'd0, 3'b010, 1'b0, 13'd8, 1, 32'h0080A103, 0);
        send_cmd(3'd3, 5'd0, 5'd1, 5'd2, 3'b010, 1'b0, 13'd4, 1, 32'h0020A223, 0);
        wait_obs(2);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) $display("[TB] FAIL ldst_write: no write seen, required %h at %0d", e.data, e.addr);
            else begin
                o = obs_q.pop_front();
                if (o.addr !== e.addr || o.data !== e.data || o.we_cycles != 3 || o.ready_seen)
                    $display("[TB] FAIL ldst_write: got %h@%0d we=%0d rdy=%0b required %h@%0d we=3 rdy=0",
                             o.data, o.addr, o.we_cycles, o.ready_seen, e.data, e.addr);
                else n_pass++;
            end
        end
        n_checks++;
        if (count !== 7'd3) $display("[TB] FAIL ldst_count: count=%0d required 3", count);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        obs_t o;
        exp_t e;
        ack_delay = 0;
        send_cmd(3'd2, 5'd3, 5'd1, 5'd2, 3'b000, 1'b1, 13'd0, 1, 32'h402081B3, 0);
        send_cmd(3'd4, 5'd0, 5'd1, 5'd2, 3'b000, 1'b0, 13'h1FFC, 1, 32'hFE208EE3, 0);
        send_cmd(3'd1, 5'd5, 5'd6, 5'd0, 3'b101, 1'b1, 13'd3, 1, 32'h40335293, 0);
        wait_obs(3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) $display("[TB] FAIL b2b_write: no write seen, required %h at %0d", e.data, e.addr);
            else begin
                o = obs_q.pop_front();
                if (o.addr !== e.addr || o.data !== e.data)
                    $display("[TB] FAIL b2b_write: got %h@%0d required %h@%0d", o.data, o.addr, e.data, e.addr);
                else n_pass++;
            end
        end
        n_checks++;
        if (count !== 7'd6) $display("[TB] FAIL b2b_count: count=%0d required 6", count);
        else n_pass++;
    endtask

    task automatic test_illegal();
        obs_t o;
        exp_t e;
        send_cmd(3'd6, 5'd1, 5'd1, 5'd1, 3'b000, 1'b0, 13'd0, 0, 32'h0, 0);
        n_checks++;
        if (err !== 1'b1 || imem_we !== 1'b0) $display("[TB] FAIL illegal_err: err=%b we=%b required 1/0", err, imem_we);
        else n_pass++;
        @(posedge clk);
        #1;
        n_checks++;
        if (err !== 1'b0 || imem_we !== 1'b0 || count !== 7'd6 || cmd_ready !== 1'b1)
            $display("[TB] FAIL illegal_after: err=%b we=%b count=%0d rdy=%b required 0/0/6/1", err, imem_we, count, cmd_ready);
        else n_pass++;
`ifdef ENC_IMM_CHECK_EN
        send_cmd(3'd4, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 13'd3, 0, 32'h0, 0);
        n_checks++;
        if (err !== 1'b1 || imem_we !== 1'b0) $display("[TB] FAIL branch_range: err=%b we=%b required 1/0", err, imem_we);
        else n_pass++;
        wait_obs(0);
`else
        send_cmd(3'd4, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 13'd3, 1, 32'h00000163, 0);
        n_checks++;
        if (err !== 1'b0) $display("[TB] FAIL branch_trunc_err: err=%b required 0", err);
        else n_pass++;
        wait_obs(1);
`endif
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) $display("[TB] FAIL branch_trunc: no write seen, required %h at %0d", e.data, e.addr);
            else begin
                o = obs_q.pop_front();
                if (o.addr !== e.addr || o.data !== e.data)
                    $display("[TB] FAIL branch_trunc: got %h@%0d required %h@%0d", o.data, o.addr, e.data, e.addr);
                else n_pass++;
            end
        end
        n_checks++;
        if (count !== model_count[ADDR_W:0]) $display("[TB] FAIL illegal_count: count=%0d required %0d", count, model_count);
        else n_pass++;
    endtask

    task automatic test_start_idle();
        obs_t o;
        exp_t e;
        send_cmd(3'd1, 5'd7, 5'd0, 5'd0, 3'b000, 1'b0, 13'd9, 1, 32'h00900393, 1);
        wait_obs(1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) $display("[TB] FAIL start_idle_write: no write seen, required %h at %0d", e.data, e.addr);
            else begin
                o = obs_q.pop_front();
                if (o.addr !== e.addr || o.data !== e.data || o.addr !== 6'd0)
                    $display("[TB] FAIL start_idle_write: got %h@%0d required %h@0", o.data, o.addr, e.data);
                else n_pass++;
            end
        end
        n_checks++;
        if (count !== 7'd1) $display("[TB] FAIL start_idle_count: count=%0d required 1", count);
        else n_pass++;
    endtask

    task automatic test_fill();
        obs_t o;
        exp_t e;
        int first;
        logic [31:0] w;
        ack_delay = 0;
        first = model_count;
        for (int i = first; i < DEPTH; i++) begin
            w = (i << 20) | ((i & 31) << 7) | 32'h13;
            send_cmd(3'd1, i[4:0], 5'd0, 5'd0, 3'b000, 1'b0, i[12:0], 1, w, 0);
        end
        wait_obs(DEPTH - first);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) $display("[TB] FAIL fill_write: no write seen, required %h at %0d", e.data, e.addr);
            else begin
                o = obs_q.pop_front();
                if (o.addr !== e.addr || o.data !== e.data)
                    $display("[TB] FAIL fill_write: got %h@%0d required %h@%0d", o.data, o.addr, e.data, e.addr);
                else n_pass++;
            end
        end
        n_checks++;
        if (full !== 1'b1 || cmd_ready !== 1'b0 || count !== 7'd64)
            $display("[TB] FAIL fill_full: full=%b rdy=%b count=%0d required 1/0/64", full, cmd_ready, count);
        else n_pass++;
        cmd_valid = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        n_checks++;
        if (imem_we !== 1'b0 || full !== 1'b1) $display("[TB] FAIL full_blocks: we=%b full=%b required 0/1", imem_we, full);
        else n_pass++;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        model_count = 0;
        n_checks++;
        if (count !== 7'd0 || full !== 1'b0 || cmd_ready !== 1'b1)
            $display("[TB] FAIL full_start: count=%0d full=%b rdy=%b required 0/0/1", count, full, cmd_ready);
        else n_pass++;
        send_cmd(3'd1, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 13'd5, 1, 32'h00500093, 0);
        wait_obs(1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) $display("[TB] FAIL restart_write: no write seen, required %h at %0d", e.data, e.addr);
            else begin
                o = obs_q.pop_front();
                if (o.addr !== 6'd0 || o.data !== e.data)
                    $display("[TB] FAIL restart_write: got %h@%0d required %h@0", o.data, o.addr, e.data);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid_write();
        ack_delay = 50;
        send_cmd(3'd1, 5'd2, 5'd0, 5'd0, 3'b000, 1'b0, 13'd1, 1, 32'h00100113, 0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (imem_we !== 1'b1) $display("[TB] FAIL midwrite_we: we=%b required 1", imem_we);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (imem_we !== 1'b0 || count !== 7'd0)
            $display("[TB] FAIL async_reset: we=%b count=%0d required 0/0", imem_we, count);
        else n_pass++;
        exp_q.delete();
        obs_q.delete();
        model_count = 0;
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        n_checks++;
        if (cmd_ready !== 1'b1 || imem_we !== 1'b0 || obs_q.size() != 0)
            $display("[TB] FAIL after_reset: rdy=%b we=%b writes=%0d required 1/0/0", cmd_ready, imem_we, obs_q.size());
        else n_pass++;
        ack_delay = 0;
    endtask

    initial begin
        $display("[TB] instr_encoder bench starting");
        test_reset();
        test_opimm();
        test_load_store_delayed();
        test_back_to_back();
        test_illegal();
        test_start_idle();
        test_fill();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
